bp_cce_icache_req_responder: RTL
================================

// Module: bp_cce_icache_req_responder
// PURPOSE
//  CCE-side responder for I$ LCE requests; consumes lce_req messages (rd miss, uc_rd) from one I$ LCE.
//  Fetches the target from memory and returns the line via data + set_tag LCE commands, then waits for the coh_ack.
//  For uncached reads it returns a single uc_data command with no ack phase.
//  Sits between the LCE->CCE req/resp networks, the CCE->LCE cmd network, and a single-outstanding memory port.
// PARAMETERS
//  bp_params_p     e_bp_inv_cfg  processor config; supplies paddr_width_p, lce/cce_id_width_p, icache_lce_assoc_p, cce_block_width_p
//  ack_timeout_p   1024          cycles in WAIT_ACK before timeout_o pulses (counter saturates, keeps waiting)
// PORTS
//  clk_i           in   1                        clock
//  reset_i         in   1                        asynchronous, active-high reset
//  cce_id_i        in   cce_id_width_p           this CCE's id (cmd src_id)
//  lce_req_i       in   lce_cce_req_width_lp     bp_lce_cce_req_s
//  lce_req_v_i     in   1                        request valid
//  lce_req_yumi_o  out  1                        request consumed this cycle
//  lce_resp_i      in   lce_cce_resp_width_lp    bp_lce_cce_resp_s
//  lce_resp_v_i    in   1                        response valid
//  lce_resp_yumi_o out  1                        response consumed this cycle
//  lce_cmd_o       out  lce_cmd_width_lp         bp_lce_cmd_s
//  lce_cmd_v_o     out  1                        command valid
//  lce_cmd_ready_i in   1                        command network ready
//  mem_cmd_o       out  cce_mem_msg_width_lp     bp_cce_mem_msg_s (read)
//  mem_cmd_v_o     out  1                        memory command valid
//  mem_cmd_ready_i in   1                        memory ready
//  mem_resp_i      in   cce_mem_msg_width_lp     bp_cce_mem_msg_s (read data)
//  mem_resp_v_i    in   1                        memory response valid
//  mem_resp_yumi_o out  1                        memory response consumed
//  busy_o          out  1                        state != READY
//  error_o         out  1                        1-cycle pulse: unsupported req type or unexpected resp
//  timeout_o       out  1                        1-cycle pulse when ack counter reaches ack_timeout_p
// BEHAVIOUR
//  Reset: state=READY; all *_v_o, *_yumi_o, busy_o, error_o, timeout_o = 0; latched src_id/addr/way/data/uc flag = 0.
//  Reset asserted mid-transaction aborts immediately to READY; no partial command completes afterwards.
//  Handshakes: *_v_o held with stable payload until ready_i sampled high (transfer on v_o&ready_i).
//  yumi_o only asserted combinationally when matching v_i is high.
//  FSM (3-bit enum):
//   READY: lce_req_yumi_o=lce_req_v_i. rd -> latch src_id, addr, lru_way_id -> MEM_CMD (uc=0).
//     uc_rd -> latch src_id, addr -> MEM_CMD (uc=1). Other msg_type: consume, error_o=1, stay READY.
//   MEM_CMD: mem_cmd_v_o=1; addr = rd: addr with low log2(cce_block_width_p/8) bits zeroed, size = block;
//     uc: addr as received, size 8B. Advance to MEM_RESP on mem_cmd_ready_i.
//   MEM_RESP: mem_resp_yumi_o=mem_resp_v_i; latch data; -> uc ? SEND_UC_DATA : SEND_DATA.
//   SEND_DATA: cmd e_lce_cmd_data, dst=src_id, way=lru_way, data=block -> SEND_SET_TAG on ready.
//   SEND_SET_TAG: cmd e_lce_cmd_set_tag, addr=block addr, way=lru_way, state=shared -> WAIT_ACK on ready.
//   SEND_UC_DATA: cmd e_lce_cmd_uc_data, addr=req addr, data low 64b -> READY on ready.
//   WAIT_ACK: lce_resp_yumi_o=lce_resp_v_i. coh_ack from latched src_id -> READY.
//     Any other resp type/src: consumed, error_o=1, stay. Counter +1/cycle, cleared on entry;
//     timeout_o pulses once at ack_timeout_p, then the counter saturates.
//  All cmds: src_id=cce_id_i. Exactly one transaction outstanding; lce_req not consumed unless READY.
//  Min latency rd (all ready, mem resp next cycle): req accept T0, mem_cmd T1, resp T2, data T3, set_tag T4, ack >=T5.
//  Responses in non-WAIT_ACK states are not consumed (yumi=0); they remain pending at the network.
// TESTING
//  rd miss addr 0x8000_1234, lru_way 3, all ready -> mem addr 0x8000_1200; data cmd way 3, then set_tag; ack -> READY, busy_o 0.
//  uc_rd addr 0x0010_0004 -> mem size 8B addr 0x0010_0004; one uc_data cmd; no ack awaited; next req accepted T+1.
//  lce_cmd_ready_i low 5 cycles in SEND_DATA -> lce_cmd_v_o and payload stable 5 cycles; set_tag only after.
//  WAIT_ACK gets coh_ack from wrong src_id -> yumi + error_o 1 cycle, stays; correct ack -> READY.
//  ack_timeout_p=8, no ack -> timeout_o single pulse at cycle 8; later ack still completes.
//  Async reset asserted mid SEND_SET_TAG -> outputs 0 same cycle, READY; fresh rd then completes normally.

Source files
------------

// File: rtl/bp_cce_icache_req_responder.sv
// bp_cce_icache_req_responder: CCE-side responder serving I$ read-miss and uncached-read requests from one LCE.
//
// Ports:
//   clk_i, reset_i (asynchronous, active-high), cce_id_i (src_id stamped on every command)
//   lce_req_i/_v_i/_yumi_o    LCE->CCE request, consumed only in READY
//   lce_resp_i/_v_i/_yumi_o   LCE->CCE response, consumed only in WAIT_ACK
//   lce_cmd_o/_v_o/_ready_i   CCE->LCE command (data, set_tag, uc_data)
//   mem_cmd_o/_v_o/_ready_i   memory read command, single outstanding
//   mem_resp_i/_v_i/_yumi_o   memory read data
//   busy_o (not READY), error_o (pulse), timeout_o (pulse)
//
// Message layouts, MSB first:
//   lce_req  : msg_type[2] (0 rd, 1 wr, 2 uc_rd, 3 uc_wr) | src_id | addr | lru_way_id
//   lce_resp : msg_type[2] (0 sync_ack, 1 inv_ack, 2 coh_ack, 3 wb) | src_id | addr
//   lce_cmd  : msg_type[4] (1 set_tag, 4 data, 5 uc_data) | dst_id | src_id | addr | way_id | state[3] (1 shared) | data
//   mem msg  : msg_type[2] (0 rd, 2 uc_rd) | size[3] (log2 bytes) | addr | data
module bp_cce_icache_req_responder #(
    parameter int paddr_width_p       = 40,
    parameter int lce_id_width_p      = 4,
    parameter int cce_id_width_p      = 4,
    parameter int icache_lce_assoc_p  = 8,
    parameter int cce_block_width_p   = 512,
    parameter int ack_timeout_p       = 1024,
    localparam int way_width_lp          = $clog2(icache_lce_assoc_p),
    localparam int lce_cce_req_width_lp  = 2 + lce_id_width_p + paddr_width_p + way_width_lp,
    localparam int lce_cce_resp_width_lp = 2 + lce_id_width_p + paddr_width_p,
    localparam int lce_cmd_width_lp      = 4 + lce_id_width_p + cce_id_width_p + paddr_width_p
                                           + way_width_lp + 3 + cce_block_width_p,
    localparam int cce_mem_msg_width_lp  = 2 + 3 + paddr_width_p + cce_block_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [cce_id_width_p-1:0]        cce_id_i,
    input  logic [lce_cce_req_width_lp-1:0]  lce_req_i,
    input  logic                             lce_req_v_i,
    output logic                             lce_req_yumi_o,
    input  logic [lce_cce_resp_width_lp-1:0] lce_resp_i,
    input  logic                             lce_resp_v_i,
    output logic                             lce_resp_yumi_o,
    output logic [lce_cmd_width_lp-1:0]      lce_cmd_o,
    output logic                             lce_cmd_v_o,
    input  logic                             lce_cmd_ready_i,
    output logic [cce_mem_msg_width_lp-1:0]  mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0]  mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic                             busy_o,
    output logic                             error_o,
    output logic                             timeout_o
);
    typedef struct packed {
        logic [1:0]                msg_type;
        logic [lce_id_width_p-1:0] src_id;
        logic [paddr_width_p-1:0]  addr;
        logic [way_width_lp-1:0]   lru_way_id;
    } lce_req_s;

    typedef struct packed {
        logic [1:0]                msg_type;
        logic [lce_id_width_p-1:0] src_id;
        logic [paddr_width_p-1:0]  addr;
    } lce_resp_s;

    typedef struct packed {
        logic [3:0]                   msg_type;
        logic [lce_id_width_p-1:0]    dst_id;
        logic [cce_id_width_p-1:0]    src_id;
        logic [paddr_width_p-1:0]     addr;
        logic [way_width_lp-1:0]      way_id;
        logic [2:0]                   state;
        logic [cce_block_width_p-1:0] data;
    } lce_cmd_s;

    typedef struct packed {
        logic [1:0]                   msg_type;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } mem_msg_s;

    typedef enum logic [2:0] {
        e_ready, e_mem_cmd, e_mem_resp, e_send_data, e_send_set_tag, e_send_uc_data, e_wait_ack
    } state_e;

    localparam logic [1:0] req_rd_lp      = 2'd0;
    localparam logic [1:0] req_uc_rd_lp   = 2'd2;
    localparam logic [1:0] resp_coh_ack_lp = 2'd2;
    localparam logic [3:0] cmd_set_tag_lp = 4'd1;
    localparam logic [3:0] cmd_data_lp    = 4'd4;
    localparam logic [3:0] cmd_uc_data_lp = 4'd5;
    localparam logic [2:0] coh_shared_lp  = 3'd1;
    localparam logic [1:0] mem_rd_lp      = 2'd0;
    localparam logic [1:0] mem_uc_rd_lp   = 2'd2;
    localparam int         blk_off_lp     = $clog2(cce_block_width_p / 8);
    localparam logic [2:0] size_blk_lp    = 3'(blk_off_lp);
    localparam logic [2:0] size_8b_lp     = 3'd3;
    localparam int         cnt_width_lp   = $clog2(ack_timeout_p + 1);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp  = cnt_width_lp'(ack_timeout_p);
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(ack_timeout_p - 1);

    lce_req_s  req;
    lce_resp_s resp;
    mem_msg_s  mem_resp;
    mem_msg_s  mem_cmd;
    lce_cmd_s  cmd;

    state_e                        state_q, state_d;
    logic [lce_id_width_p-1:0]     src_q, src_d;
    logic [paddr_width_p-1:0]      addr_q, addr_d;
    logic [way_width_lp-1:0]       way_q, way_d;
    logic [cce_block_width_p-1:0]  data_q, data_d;
    logic                          uc_q, uc_d;
    logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
    logic [paddr_width_p-1:0]      blk_addr;
    logic                          unused_bits;

    assign req       = lce_req_i;
    assign resp      = lce_resp_i;
    assign mem_resp  = mem_resp_i;
    assign lce_cmd_o = cmd;
    assign mem_cmd_o = mem_cmd;
    assign busy_o    = state_q != e_ready;
    assign blk_addr  = {addr_q[paddr_width_p-1:blk_off_lp], {blk_off_lp{1'b0}}};
    assign unused_bits = ^{resp.addr, mem_resp.msg_type, mem_resp.size, mem_resp.addr};

    // Payloads come only from latched state, so they hold steady while a valid waits for ready.
    always_comb begin
        mem_cmd          = '0;
        mem_cmd.msg_type = uc_q ? mem_uc_rd_lp : mem_rd_lp;
        mem_cmd.size     = uc_q ? size_8b_lp : size_blk_lp;
        mem_cmd.addr     = uc_q ? addr_q : blk_addr;
        cmd              = '0;
        cmd.msg_type     = state_q == e_send_set_tag ? cmd_set_tag_lp
                         : state_q == e_send_uc_data ? cmd_uc_data_lp : cmd_data_lp;
        cmd.dst_id       = src_q;
        cmd.src_id       = cce_id_i;
        cmd.addr         = uc_q ? addr_q : blk_addr;
        cmd.way_id       = way_q;
        cmd.state        = state_q == e_send_set_tag ? coh_shared_lp : 3'd0;
        cmd.data         = state_q == e_send_data ? data_q
                         : state_q == e_send_uc_data ? {{(cce_block_width_p-64){1'b0}}, data_q[63:0]}
                         : '0;
    end

    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        addr_d          = addr_q;
        way_d           = way_q;
        data_d          = data_q;
        uc_d            = uc_q;
        cnt_d           = cnt_q;
        lce_req_yumi_o  = 1'b0;
        lce_resp_yumi_o = 1'b0;
        lce_cmd_v_o     = 1'b0;
        mem_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        error_o         = 1'b0;
        timeout_o       = 1'b0;
        case (state_q)
            e_ready: begin
                // Reset holds the FSM here, so a request must not be dropped by a yumi during reset.
                lce_req_yumi_o = lce_req_v_i & ~reset_i;
                if (lce_req_yumi_o) begin
                    if (req.msg_type == req_rd_lp || req.msg_type == req_uc_rd_lp) begin
                        uc_d    = req.msg_type == req_uc_rd_lp;
                        src_d   = req.src_id;
                        addr_d  = req.addr;
                        way_d   = uc_d ? '0 : req.lru_way_id;
                        state_d = e_mem_cmd;
                    end else begin
                        error_o = 1'b1;
                    end
                end
            end
            e_mem_cmd: begin
                mem_cmd_v_o = 1'b1;
                state_d     = mem_cmd_ready_i ? e_mem_resp : e_mem_cmd;
            end
            e_mem_resp: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    data_d  = mem_resp.data;
                    state_d = uc_q ? e_send_uc_data : e_send_data;
                end
            end
            e_send_data: begin
                lce_cmd_v_o = 1'b1;
                state_d     = lce_cmd_ready_i ? e_send_set_tag : e_send_data;
            end
            e_send_set_tag: begin
                lce_cmd_v_o = 1'b1;
                state_d     = lce_cmd_ready_i ? e_wait_ack : e_send_set_tag;
                cnt_d       = '0;
            end
            e_send_uc_data: begin
                lce_cmd_v_o = 1'b1;
                state_d     = lce_cmd_ready_i ? e_ready : e_send_uc_data;
            end
            e_wait_ack: begin
                lce_resp_yumi_o = lce_resp_v_i;
                // Saturating one past the last count makes the timeout a single pulse.
                cnt_d     = cnt_q == cnt_max_lp ? cnt_q : cnt_q + 1'b1;
                timeout_o = cnt_q == cnt_last_lp;
                if (lce_resp_v_i) begin
                    if (resp.msg_type == resp_coh_ack_lp && resp.src_id == src_q)
                        state_d = e_ready;
                    else
                        error_o = 1'b1;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            src_q   <= '0;
            addr_q  <= '0;
            way_q   <= '0;
            data_q  <= '0;
            uc_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            way_q   <= way_d;
            data_q  <= data_d;
            uc_q    <= uc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
